// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect/halt control, instruction memory read port and decode handshake of the fetch queue.
interface fetch_queue_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH + 1);
    logic               flush;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic [PC_W-1:0]    mem_raddr;
    logic               mem_ren;
    logic [INSTR_W-1:0] mem_rdata;
    logic               deq_valid;
    logic               deq_ready;
    logic [INSTR_W-1:0] deq_instr;
    logic [PC_W-1:0]    deq_pc;
    logic [CW-1:0]      count;
    modport master (
        input  flush, redirect_pc, halt, mem_rdata, deq_ready,
        output mem_raddr, mem_ren, deq_valid, deq_instr, deq_pc, count
    );
    modport slave (
        output flush, redirect_pc, halt, mem_rdata, deq_ready,
        input  mem_raddr, mem_ren, deq_valid, deq_instr, deq_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner issuing 1-cycle-latency reads and buffering {instr, pc} in a DEPTH-entry FIFO for decode.
module fetch_queue #(
    parameter int INSTR_W  = 16,
    parameter int PC_W     = 16,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0,
    parameter int BYPASS   = 0
) (
    input logic          clk,
    input logic          rst_n,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [PC_W-1:0]    pc, ipc;
    logic               inflight;
    logic [AW-1:0]      wp, rp;
    logic [CW-1:0]      cnt;
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [PC_W-1:0]    q_pc [DEPTH];
    logic empty, rsp, byp, ren, deq, wr, rd;
    // Credit counts the in-flight read but not a same-cycle dequeue, so a write always has room.
    always_comb begin
        empty         = cnt == '0;
        rsp           = inflight & ~bus.flush;
        byp           = (BYPASS != 0) & rsp & empty;
        ren           = rst_n & ~bus.halt & ~bus.flush &
                        (({1'b0, cnt} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH));
        bus.deq_valid = ~bus.flush & (~empty | byp);
        deq           = bus.deq_valid & bus.deq_ready;
        wr            = rsp & ~(byp & bus.deq_ready);
        rd            = deq & ~empty;
        bus.deq_instr = !bus.deq_valid ? '0 : empty ? bus.mem_rdata : q_instr[rp];
        bus.deq_pc    = !bus.deq_valid ? '0 : empty ? ipc : q_pc[rp];
    end
    assign bus.mem_ren   = ren;
    assign bus.mem_raddr = pc;
    assign bus.count     = cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= PC_W'(RESET_PC);
            ipc      <= '0;
            inflight <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
        end else if (bus.flush) begin
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
        end else begin
            inflight <= ren;
            if (ren) begin
                pc  <= pc + PC_W'(PC_STEP);
                ipc <= pc;
            end
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            cnt <= cnt + CW'(wr) - CW'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) begin
            q_instr[wp] <= bus.mem_rdata;
            q_pc[wp]    <= ipc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench running a BYPASS=0 and a BYPASS=1 fetch_queue side by side.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic halt = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic ready [2];
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    fetch_queue_if #(.INSTR_W(16), .PC_W(16), .DEPTH(DEPTH)) b0 ();
    fetch_queue_if #(.INSTR_W(16), .PC_W(16), .DEPTH(DEPTH)) b1 ();
    assign b0.flush = flush;
    assign b0.redirect_pc = redirect_pc;
    assign b0.halt = halt;
    assign b0.deq_ready = ready[0];
    assign b1.flush = flush;
    assign b1.redirect_pc = redirect_pc;
    assign b1.halt = halt;
    assign b1.deq_ready = ready[1];
    fetch_queue #(.DEPTH(DEPTH), .BYPASS(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    fetch_queue #(.DEPTH(DEPTH), .BYPASS(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    function automatic logic [15:0] f(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction
    // Instruction memory: data for last cycle's address.
    always @(posedge clk) begin
        if (b0.mem_ren) b0.mem_rdata <= f(b0.mem_raddr);
        if (b1.mem_ren) b1.mem_rdata <= f(b1.mem_raddr);
    end
    logic        dv [2], ren [2];
    logic [15:0] dpc [2], dins [2], raddr [2];
    logic [2:0]  cnt [2];
    assign dv[0] = b0.deq_valid;
    assign dv[1] = b1.deq_valid;
    assign ren[0] = b0.mem_ren;
    assign ren[1] = b1.mem_ren;
    assign dpc[0] = b0.deq_pc;
    assign dpc[1] = b1.deq_pc;
    assign dins[0] = b0.deq_instr;
    assign dins[1] = b1.deq_instr;
    assign raddr[0] = b0.mem_raddr;
    assign raddr[1] = b1.mem_raddr;
    assign cnt[0] = b0.count;
    assign cnt[1] = b1.count;
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", name, k, act, exp, $time);
        end
    endtask
    // Reference model: fetch PC, one in-flight slot and a queue of buffered PCs.
    logic [15:0] mpc [2], mipc [2];
    bit          minf [2];
    logic [15:0] mq [2][$];
    logic [15:0] sb [2][$];
    initial begin
        int n;
        bit byp, edv, eren;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    mpc[k] = 16'h0;
                    mipc[k] = 16'h0;
                    minf[k] = 1'b0;
                    mq[k].delete();
                    sb[k].delete();
                    chk("rst_ren", k, 32'(ren[k]), 0);
                    chk("rst_valid", k, 32'(dv[k]), 0);
                    chk("rst_count", k, 32'(cnt[k]), 0);
                    chk("rst_raddr", k, 32'(raddr[k]), 0);
                    continue;
                end
                n = mq[k].size();
                byp = (k == 1) && minf[k] && !flush && n == 0;
                edv = !flush && (n > 0 || byp);
                eren = !halt && !flush && (n + int'(minf[k]) < DEPTH);
                chk("mem_ren", k, 32'(ren[k]), 32'(eren));
                chk("mem_raddr", k, 32'(raddr[k]), 32'(mpc[k]));
                chk("count", k, 32'(cnt[k]), 32'(n));
                chk("deq_valid", k, 32'(dv[k]), 32'(edv));
                if (edv) chk("head_pc", k, 32'(dpc[k]), 32'(n > 0 ? mq[k][0] : mipc[k]));
                if (flush) begin
                    mq[k].delete();
                    sb[k].delete();
                    minf[k] = 1'b0;
                    mpc[k] = redirect_pc;
                end else begin
                    if (minf[k] && !(byp && ready[k])) mq[k].push_back(mipc[k]);
                    if (edv && ready[k] && n > 0) void'(mq[k].pop_front());
                    if (eren) begin
                        sb[k].push_back(mpc[k]);
                        mipc[k] = mpc[k];
                        mpc[k] = mpc[k] + 16'd2;
                    end
                    minf[k] = eren;
                end
            end
        end
    end
    // Monitor: every accepted entry must be the oldest issued, unflushed PC with its memory word.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (dv[k] && ready[k] && rst_n) begin
                    if (sb[k].size() == 0) begin
                        chk("sb_underflow", k, 32'(dpc[k]), 32'hFFFF_FFFF);
                    end else begin
                        e = sb[k].pop_front();
                        chk("deq_pc", k, 32'(dpc[k]), 32'(e));
                        chk("deq_instr", k, 32'(dins[k]), 32'(f(e)));
                    end
                end else if (!dv[k]) begin
                    chk("idle_pc", k, 32'(dpc[k]), 0);
                    chk("idle_instr", k, 32'(dins[k]), 0);
                end
            end
        end
    end
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic pulse_flush(input logic [15:0] pc);
        flush = 1'b1;
        redirect_pc = pc;
        step(1);
        flush = 1'b0;
    endtask
    initial begin
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(12);
        ready[0] = 1'b0;
        ready[1] = 1'b0;
        step(10);
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        step(10);
        ready[0] = 1'b0;
        ready[1] = 1'b0;
        step(3);
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        pulse_flush(16'h0040);
        step(8);
        ready[0] = 1'b0;
        ready[1] = 1'b0;
        step(3);
        halt = 1'b1;
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        step(6);
        halt = 1'b0;
        step(6);
        flush = 1'b1;
        redirect_pc = 16'h0100;
        step(1);
        redirect_pc = 16'h0200;
        step(1);
        flush = 1'b0;
        step(6);
        pulse_flush(16'hFFFC);
        for (int i = 0; i < 2000; i++) begin
            ready[0] = ($urandom % 4) != 0;
            ready[1] = ($urandom % 3) != 0;
            halt = ($urandom % 16) == 0;
            if (($urandom % 64) == 0) begin
                flush = 1'b1;
                redirect_pc = 16'($urandom) & 16'hFFFE;
            end else begin
                flush = 1'b0;
            end
            if (i == 1000) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
            step(1);
        end
        flush = 1'b0;
        halt = 1'b0;
        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
